// File: rtl/buck_pwm_ctrl.sv
// Closed-loop buck gate driver: PI compensator evaluated once per PWM period,
// counter-based gate with soft-start reference ramp and over-voltage trip.
module buck_pwm_ctrl #(
  parameter int DATA_W   = 18,
  parameter int PERIOD   = 200,
  parameter int CNT_W    = 16,
  parameter int KP_SHIFT = 2,
  parameter int KI_SHIFT = 6,
  parameter int D_MIN    = 0,
  parameter int D_MAX    = 180,
  parameter int SS_STEP  = 64,
  parameter int OV_LIMIT = 40960
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] v_ref,
  input  logic signed [DATA_W-1:0] v_meas,
  input  logic                     v_meas_valid,
  input  logic                     fault_clr,
  output logic                     gate,
  output logic [CNT_W-1:0]         duty,
  output logic [1:0]               state,
  output logic                     fault,
  output logic                     period_start
);

  localparam int ERR_W = DATA_W + 1;
  localparam int ACC_W = DATA_W + 8;
  localparam int U_W   = ACC_W + 1;

  localparam logic signed [ACC_W-1:0]  ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [U_W-1:0]    U_MAX    = U_W'(D_MAX);
  localparam logic signed [U_W-1:0]    U_MIN    = U_W'(D_MIN);
  localparam logic signed [DATA_W-1:0] OV_TH    = DATA_W'(OV_LIMIT);
  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SOFT_START = 2'd1,
    REGULATE   = 2'd2,
    FAULT      = 2'd3
  } state_t;

  state_t                    st;
  logic [CNT_W-1:0]          cnt;
  logic signed [ACC_W-1:0]   acc;
  logic signed [DATA_W-1:0]  ref_int;
  logic signed [DATA_W-1:0]  v_hold;

  logic signed [ERR_W-1:0]   err;
  logic signed [ERR_W-1:0]   ss_sum;
  logic signed [ACC_W:0]     acc_sum;
  logic signed [ACC_W-1:0]   acc_c;
  logic signed [U_W-1:0]     u;
  logic [CNT_W-1:0]          duty_next;
  logic [CNT_W-1:0]          cnt_inc;
  logic                      err_pos;
  logic                      err_neg;
  logic                      windup_hold;
  logic                      ss_done;
  logic                      active;
  logic                      trip;
  logic                      cnt_last;

  assign state = st;

  always_comb begin
    err     = ERR_W'(ref_int) - ERR_W'(v_hold);
    err_neg = err[ERR_W-1];
    err_pos = !err[ERR_W-1] && (err != '0);

    acc_sum = (ACC_W+1)'(acc) + (ACC_W+1)'(err);
    if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
      acc_c = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_c = acc_sum[ACC_W-1:0];
    end

    u = (U_W'(err) >>> KP_SHIFT) + (U_W'(acc_c) >>> KI_SHIFT);

    if (u > U_MAX) begin
      duty_next = CNT_W'(D_MAX);
    end else if (u < U_MIN) begin
      duty_next = CNT_W'(D_MIN);
    end else begin
      duty_next = u[CNT_W-1:0];
    end

    // Freeze the integrator while the output is pinned and error pushes further out.
    windup_hold = ((u > U_MAX) && err_pos) || ((u < U_MIN) && err_neg);

    ss_sum  = ERR_W'(ref_int) + ERR_W'(SS_STEP);
    ss_done = (ss_sum >= ERR_W'(v_ref));

    active   = (st == SOFT_START) || (st == REGULATE);
    trip     = active && v_meas_valid && (v_meas > OV_TH);
    cnt_last = (cnt == CNT_LAST);
    cnt_inc  = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= IDLE;
      cnt          <= '0;
      gate         <= 1'b0;
      duty         <= '0;
      fault        <= 1'b0;
      period_start <= 1'b0;
      acc          <= '0;
      ref_int      <= '0;
      v_hold       <= '0;
    end else begin
      if (v_meas_valid) begin
        v_hold <= v_meas;
      end

      case (st)
        IDLE: begin
          cnt     <= '0;
          gate    <= 1'b0;
          duty    <= '0;
          acc     <= '0;
          ref_int <= '0;
          if (en) begin
            st           <= SOFT_START;
            period_start <= 1'b1;
          end else begin
            period_start <= 1'b0;
          end
        end

        SOFT_START, REGULATE: begin
          if (trip) begin
            st           <= FAULT;
            fault        <= 1'b1;
            cnt          <= '0;
            gate         <= 1'b0;
            duty         <= '0;
            acc          <= '0;
            ref_int      <= '0;
            period_start <= 1'b0;
          end else if (!en) begin
            st           <= IDLE;
            cnt          <= '0;
            gate         <= 1'b0;
            duty         <= '0;
            acc          <= '0;
            ref_int      <= '0;
            period_start <= 1'b0;
          end else if (cnt_last) begin
            // New duty takes effect exactly as the counter wraps, so no runt pulses.
            cnt          <= '0;
            duty         <= duty_next;
            gate         <= (CNT_W'(0) < duty_next);
            period_start <= 1'b1;
            if (!windup_hold) begin
              acc <= acc_c;
            end
            if (st == SOFT_START) begin
              if (ss_done) begin
                ref_int <= v_ref;
                st      <= REGULATE;
              end else begin
                ref_int <= ss_sum[DATA_W-1:0];
              end
            end else begin
              ref_int <= v_ref;
            end
          end else begin
            cnt          <= cnt_inc;
            gate         <= (cnt_inc < duty);
            period_start <= 1'b0;
          end
        end

        FAULT: begin
          cnt          <= '0;
          gate         <= 1'b0;
          duty         <= '0;
          period_start <= 1'b0;
          if (fault_clr && !en) begin
            st    <= IDLE;
            fault <= 1'b0;
          end
        end

        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buck_pwm_ctrl.sv
// Bench for buck_pwm_ctrl: directed phases with randomized sample streams,
// checked per PWM period against a period-level PI reference model.
module tb_buck_pwm_ctrl;

  localparam int     PERIOD   = 200;
  localparam int     D_MIN    = 0;
  localparam int     D_MAX    = 180;
  localparam int     SS_STEP  = 64;
  localparam int     KP_SHIFT = 2;
  localparam int     KI_SHIFT = 6;
  localparam int     OV_LIMIT = 40960;
  localparam longint ACC_MAX  = 33554431;
  localparam longint ACC_MIN  = -33554432;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic signed [17:0] v_ref;
  logic signed [17:0] v_meas;
  logic               v_meas_valid;
  logic               fault_clr;
  logic               gate;
  logic [15:0]        duty;
  logic [1:0]         state;
  logic               fault;
  logic               period_start;

  int     checks = 0;
  int     failures = 0;
  int     gcyc = 0;
  int     cur_vref;
  int     m_state;
  longint m_ref, m_acc, m_duty, m_vhold;
  int     obs_state0, obs_duty0;
  int     st9, st10;

  buck_pwm_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .v_ref        (v_ref),
    .v_meas       (v_meas),
    .v_meas_valid (v_meas_valid),
    .fault_clr    (fault_clr),
    .gate         (gate),
    .duty         (duty),
    .state        (state),
    .fault        (fault),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_meas(input int val, input bit vld);
    v_meas       = 18'(val);
    v_meas_valid = vld;
    if (vld) m_vhold = longint'(v_meas);
  endtask

  function automatic void model_reset(input int vref);
    cur_vref = vref;
    m_ref    = 0;
    m_acc    = 0;
    m_duty   = 0;
    m_state  = 1;
  endfunction

  // One PI step from the plain arithmetic definition, plus the reference ramp.
  function automatic void model_update(input longint vh);
    longint e, a, u;
    e = m_ref - vh;
    a = m_acc + e;
    if (a > ACC_MAX) a = ACC_MAX;
    if (a < ACC_MIN) a = ACC_MIN;
    u = (e >>> KP_SHIFT) + (a >>> KI_SHIFT);
    if (!((u > D_MAX && e > 0) || (u < D_MIN && e < 0))) m_acc = a;
    m_duty = (u > D_MAX) ? D_MAX : ((u < D_MIN) ? D_MIN : u);
    if (m_state == 1) begin
      if (m_ref + SS_STEP >= cur_vref) begin
        m_ref   = cur_vref;
        m_state = 2;
      end else begin
        m_ref = m_ref + SS_STEP;
      end
    end else begin
      m_ref = cur_vref;
    end
  endfunction

  // mode 0: hold inputs, 1: random sample every 37 cycles, 2: invalid over-limit samples,
  // 3: step v_meas to 20000 at the start of the period.
  task automatic run_period(input int mode, input int vref_new);
    int     high;
    bit     shape_ok, ps_ok;
    longint snap;
    high = 0; shape_ok = 1'b1; ps_ok = 1'b1; snap = m_vhold;
    for (int p = 0; p < PERIOD; p++) begin
      @(negedge clk);
      if (p == 0) begin
        obs_state0 = int'(state);
        obs_duty0  = int'(duty);
        check("duty_at_wrap", 32'(duty), 32'(m_duty));
        check("period_state", 32'(state), 32'(m_state));
      end
      if (gate === 1'b1) high++;
      if (gate !== (longint'(p) < m_duty)) shape_ok = 1'b0;
      if (period_start !== (p == 0)) ps_ok = 1'b0;
      if (p == PERIOD - 1) snap = m_vhold;
      gcyc++;
      if (p == 0 && vref_new >= 0) begin
        v_ref    = 18'(vref_new);
        cur_vref = vref_new;
      end
      if (mode == 1 && (gcyc % 37) == 0)
        drive_meas(cur_vref + int'($urandom_range(0, 1200)) - 600, $urandom_range(0, 3) != 0);
      if (mode == 2) drive_meas(OV_LIMIT + 100, 1'b0);
      if (mode == 3 && p == 0) drive_meas(20000, 1'b1);
    end
    check("gate_high_time", 32'(high), 32'(m_duty));
    check("gate_shape", 32'(shape_ok), 32'd1);
    check("period_start_pulse", 32'(ps_ok), 32'd1);
    model_update(snap);
  endtask

  initial begin
    int g_cnt, ps_cnt;
    rst = 1'b1; en = 1'b0; v_ref = '0; v_meas = '0; v_meas_valid = 1'b0; fault_clr = 1'b0;
    m_vhold = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_gate", 32'(gate), 32'd0);
    check("reset_duty", 32'(duty), 32'd0);
    check("reset_state", 32'(state), 32'd0);
    check("reset_fault", 32'(fault), 32'd0);
    check("reset_period_start", 32'(period_start), 32'd0);

    // Soft-start to 640 from zero output: REGULATE reached at the 10th update.
    v_ref = 18'sd640; drive_meas(0, 1'b1); model_reset(640); en = 1'b1;
    st9 = -1; st10 = -1;
    for (int i = 0; i < 12; i++) begin
      run_period(0, -1);
      if (i == 9)  st9  = obs_state0;
      if (i == 10) st10 = obs_state0;
    end
    check("ss_state_before_10th", 32'(st9), 32'd1);
    check("ss_state_after_10th", 32'(st10), 32'd2);

    // Randomized regulation with jittered samples every 37 cycles.
    for (int i = 0; i < 8; i++)
      run_period(1, (i % 3 == 0) ? 1000 + int'($urandom_range(0, 2000)) : -1);

    en = 1'b0;
    @(negedge clk);
    check("disable_state", 32'(state), 32'd0);
    check("disable_gate", 32'(gate), 32'd0);
    check("disable_duty", 32'(duty), 32'd0);

    // Large target: clamp at D_MAX, then a step above target must release at once.
    v_ref = 18'sd10000; drive_meas(0, 1'b1); model_reset(10000); en = 1'b1;
    for (int i = 0; i < 200 && m_state == 1; i++) run_period(0, -1);
    repeat (3) run_period(0, -1);
    check("clamp_duty", 32'(obs_duty0), 32'd180);
    check("clamp_state", 32'(obs_state0), 32'd2);
    run_period(3, -1);
    run_period(0, -1);
    check("windup_release", 32'(obs_duty0), 32'd0);

    // Invalid over-limit samples neither trip nor reach the compensator.
    drive_meas(9000, 1'b1);
    repeat (2) run_period(0, -1);
    repeat (2) run_period(2, -1);
    check("no_trip_invalid", 32'(obs_state0), 32'd2);
    run_period(0, -1);
    check("qual_duty", 32'(obs_duty0), 32'd180);

    // Over-voltage trip mid-period with the gate high.
    repeat (61) @(negedge clk);
    check("pre_trip_gate", 32'(gate), 32'(60 < m_duty));
    drive_meas(41000, 1'b1);
    @(negedge clk);
    check("trip_state", 32'(state), 32'd3);
    check("trip_fault", 32'(fault), 32'd1);
    check("trip_gate", 32'(gate), 32'd0);
    check("trip_duty", 32'(duty), 32'd0);
    v_meas_valid = 1'b0; fault_clr = 1'b1;
    repeat (5) @(negedge clk);
    check("fault_clr_with_en_state", 32'(state), 32'd3);
    check("fault_clr_with_en_fault", 32'(fault), 32'd1);
    en = 1'b0;
    @(negedge clk);
    check("fault_exit_state", 32'(state), 32'd0);
    check("fault_exit_fault", 32'(fault), 32'd0);
    fault_clr = 1'b0;

    // Asynchronous reset between edges while the gate is high.
    v_ref = 18'sd5000; drive_meas(0, 1'b1); model_reset(5000); en = 1'b1;
    repeat (2) run_period(0, -1);
    repeat (6) @(negedge clk);
    check("pre_reset_gate", 32'(gate), 32'(5 < m_duty));
    #3 rst = 1'b1; en = 1'b0;
    #1;
    check("async_rst_gate", 32'(gate), 32'd0);
    check("async_rst_duty", 32'(duty), 32'd0);
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_fault", 32'(fault), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    g_cnt = 0; ps_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (gate !== 1'b0) g_cnt++;
      if (period_start !== 1'b0) ps_cnt++;
    end
    check("idle_gate_high", 32'(g_cnt), 32'd0);
    check("idle_period_start", 32'(ps_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
